// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_arb_pkg : channel indices, FSM encoding and defaults for spi_arbiter
// Revision    : 1.0
// ------------------------------------------------------------------
package spi_arb_pkg;

  localparam int         DATA_DEPTH_DEF = 54;
  localparam int         N_CH_DEF       = 3;

  localparam logic [1:0] CH_4002        = 2'd0;
  localparam logic [1:0] CH_2594        = 2'd1;
  localparam logic [1:0] CH_INT         = 2'd2;
  localparam logic [1:0] TGT_INVALID    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CONFIRM = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_arb2 : two-request round-robin grant, pointer moves on every grant
// Revision : 1.0
// ------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic r_prio;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = r_prio ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (|o_gnt) begin
      r_prio <= o_gnt[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_arbiter : shares three spi_master channels between two requesters
// Revision    : 1.0
// ------------------------------------------------------------------
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int DATA_DEPTH      = DATA_DEPTH_DEF,
  parameter int N_CH            = N_CH_DEF,
  parameter int CONFIRM_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [1:0]            r0_target,
  input  logic                  r0_dir,
  input  logic [7:0]            r0_depth,
  input  logic [DATA_DEPTH-1:0] r0_data,
  output logic                  r0_done,
  output logic                  r0_err,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [1:0]            r1_target,
  input  logic                  r1_dir,
  input  logic [7:0]            r1_depth,
  input  logic [DATA_DEPTH-1:0] r1_data,
  output logic                  r1_done,
  output logic                  r1_err,
  output logic [N_CH-1:0]       spi_start,
  input  logic [N_CH-1:0]       spi_ready,
  output logic                  spi_dir,
  output logic [7:0]            spi_data_depth,
  output logic [DATA_DEPTH-1:0] spi_data_tx,
  output logic [N_CH-1:0]       ch_busy
);

  localparam int            c_timer_w    = $clog2(CONFIRM_TIMEOUT + 1);
  localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(CONFIRM_TIMEOUT - 1);

  arb_state_t             r_state, w_state_nxt;
  logic [c_timer_w-1:0]   r_timer;
  logic [1:0]             r_tgt;
  logic                   r_cur;
  logic [N_CH-1:0]        r_busy;
  logic [N_CH-1:0]        r_owner;
  logic                   r_dir;
  logic [7:0]             r_depth;
  logic [DATA_DEPTH-1:0]  r_data;
  logic [1:0]             r_done;
  logic [1:0]             r_err;

  logic [1:0]             w_valid, w_bad, w_elig, w_gnt;
  logic [1:0]             w_tgt   [2];
  logic [7:0]             w_depth [2];
  logic [N_CH:0]          w_busy_x, w_ready_x;
  logic                   w_idle, w_sel, w_acc, w_cfm_drop, w_timeout;

  assign w_valid    = {r1_valid, r0_valid};
  assign w_tgt[0]   = r0_target;
  assign w_tgt[1]   = r1_target;
  assign w_depth[0] = r0_depth;
  assign w_depth[1] = r1_depth;

  // The padding bit makes the invalid target look busy and never ready
  assign w_busy_x   = {1'b1, r_busy};
  assign w_ready_x  = {1'b0, spi_ready};

  // No grant is offered while reset is asserted so nothing is accepted and lost
  assign w_idle     = rst_n && (r_state == ST_IDLE);

  always_comb begin
    w_bad  = '0;
    w_elig = '0;
    for (int n = 0; n < 2; n++) begin
      w_bad[n]  = (w_tgt[n] == TGT_INVALID) || (w_depth[n] == 8'd0) ||
                  (w_depth[n] > 8'(DATA_DEPTH));
      w_elig[n] = w_idle && w_valid[n] &&
                  (w_bad[n] || (!w_busy_x[w_tgt[n]] && w_ready_x[w_tgt[n]]));
    end
  end

  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (w_elig),
    .o_gnt (w_gnt)
  );

  assign w_sel      = w_gnt[1];
  assign w_acc      = |w_gnt;
  assign r0_ready   = w_gnt[0];
  assign r1_ready   = w_gnt[1];

  assign w_cfm_drop = (r_state == ST_CONFIRM) && !w_ready_x[r_tgt];
  assign w_timeout  = (r_state == ST_CONFIRM) && w_ready_x[r_tgt] && (r_timer == c_timer_last);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_acc && !w_bad[w_sel]) w_state_nxt = ST_ISSUE;
      ST_ISSUE:   w_state_nxt = ST_CONFIRM;
      ST_CONFIRM: if (w_cfm_drop || w_timeout) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    spi_start = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      spi_start[ch] = (r_state == ST_ISSUE) && (r_tgt == 2'(ch));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_tgt   <= '0;
      r_cur   <= 1'b0;
      r_busy  <= '0;
      r_owner <= '0;
      r_dir   <= 1'b0;
      r_depth <= '0;
      r_data  <= '0;
      r_done  <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= '0;
      r_err   <= '0;

      if (w_acc) begin
        if (w_bad[w_sel]) begin
          r_err[w_sel] <= 1'b1;
        end else begin
          r_dir   <= w_sel ? r1_dir   : r0_dir;
          r_depth <= w_sel ? r1_depth : r0_depth;
          r_data  <= w_sel ? r1_data  : r0_data;
          r_tgt   <= w_tgt[w_sel];
          r_cur   <= w_sel;
        end
      end

      if (r_state == ST_ISSUE) begin
        r_timer <= '0;
      end else if (r_state == ST_CONFIRM) begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_timeout) begin
        r_err[r_cur] <= 1'b1;
      end

      // Completion and confirmation never hit the same channel in one cycle
      for (int ch = 0; ch < N_CH; ch++) begin
        if (r_busy[ch] && spi_ready[ch]) begin
          r_busy[ch]            <= 1'b0;
          r_done[r_owner[ch]]   <= 1'b1;
        end else if (w_cfm_drop && (r_tgt == 2'(ch))) begin
          r_busy[ch]  <= 1'b1;
          r_owner[ch] <= r_cur;
        end
      end
    end
  end

  assign spi_dir        = r_dir;
  assign spi_data_depth = r_depth;
  assign spi_data_tx    = r_data;
  assign ch_busy        = r_busy;
  assign r0_done        = r_done[0];
  assign r1_done        = r_done[1];
  assign r0_err         = r_err[0];
  assign r1_err         = r_err[1];

endmodule
`default_nettype wire

// File: doc/spi_arbiter.md
# spi_arbiter

Shares the three `spi_master` channels (ADF4002, LMX2594, internal TRX/AUX bus) between two command requesters: the UART command path and the LVDS SPI-listener path. The arbiter drives the shared `spi_dir`/`spi_data_depth`/`spi_data_tx` bus and the per-channel `spi_start` bits. It also confirms each launch and reports per-requester done/error pulses. It sits between `process` and the `spi_master` instances.

## Interface
- DATA_DEPTH, 54: width of the SPI payload bus; matches `spi_master` data_depth.
- N_CH, 3: number of SPI channels; fixed encoding 0=ADF4002, 1=LMX2594, 2=internal.
- CONFIRM_TIMEOUT, 8: cycles allowed for `spi_ready[tgt]` to drop after start.
- clk  in  1  system clock (100 MHz); single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- rN_valid  in  1  requester N (N=0,1) command valid.
- rN_ready  out  1  command accepted when valid&&ready.
- rN_target  in  2  channel select; 3 is invalid.
- rN_dir  in  1  passed to spi_dir.
- rN_depth  in  8  bit count, legal 1..DATA_DEPTH.
- rN_data  in  DATA_DEPTH  payload.
- rN_done  out  1  one-cycle pulse when that requester's transfer completes.
- rN_err  out  1  one-cycle pulse on reject or confirm timeout.
- spi_start  out  N_CH  one-cycle launch pulse per channel.
- spi_ready  in  N_CH  channel idle flags from `spi_master`.
- spi_dir  out  1, spi_data_depth  out  8, spi_data_tx  out  DATA_DEPTH  shared command bus.
- ch_busy  out  N_CH  channel owned by an in-flight transfer.

## Operation
- FSM with three states: IDLE, ISSUE, CONFIRM.
- **IDLE:** requester N is eligible when rN_valid=1, target<3, !ch_busy[tgt] and spi_ready[tgt]=1.
  - rN_ready is asserted combinationally for the single granted requester.
  - If both requesters are eligible, grant the one not served last (round-robin pointer, reset value 0 gives r0 priority).
  - An ineligible requester never blocks the other; there is no head-of-line blocking across targets.
- **Rejects:** a valid command with target==3, depth==0 or depth>DATA_DEPTH is accepted immediately (ready=1) whenever the FSM is in IDLE. It produces an rN_err pulse next cycle, with no start and no state change. Rejects take part in round-robin like normal grants.
- **On accept:** register the bus fields, owner and target, then go to ISSUE.
- **ISSUE:** spi_start[tgt]=1 for exactly one cycle, then go to CONFIRM with the timer cleared.
- **CONFIRM:**
  - If spi_ready[tgt]=0: set ch_busy[tgt], record owner[tgt], go to IDLE.
  - If the timer reaches CONFIRM_TIMEOUT: err pulse to owner, ch_busy stays 0, go to IDLE.
- **Completion:** for each channel with ch_busy=1, spi_ready=1 clears ch_busy and pulses done to owner[ch] the following cycle. Several channels may be in flight concurrently, because `spi_master` latches the bus on start.
- **Simultaneous events:** done and err to one requester from different channels in the same cycle both assert. A channel whose busy clears this cycle becomes eligible next cycle, not the same cycle.
- **Reset (also mid-transfer):** all state is cleared and in-flight transfers are dropped silently.
  - Outputs after reset: spi_start=0, rN_ready=0, rN_done=0, rN_err=0, ch_busy=0, bus=0, FSM=IDLE.

## Timing
- Accept at cycle T (IDLE).
- Bus valid from T+1 and held until the next accept.
- spi_start pulse at T+1.
- CONFIRM starts at T+2; ch_busy=1 the cycle after spi_ready drops is observed.
- Back-to-back throughput: one launch per 3 cycles minimum (IDLE, ISSUE, CONFIRM with immediate drop).
- Done latency: 1 cycle after spi_ready rises.
- Reject err: T+1.
- Timeout err: T+2+CONFIRM_TIMEOUT.

## Structure
- `spi_arb_pkg`: channel index constants (CH_4002=0, CH_2594=1, CH_INT=2), TGT_INVALID=3, FSM state enum, DATA_DEPTH default.
- Sub-module `rr_arb2`: two-request round-robin grant with pointer update on accept.

## Test plan
- r0 sends target 1, depth 24, data 0x123456; the BFM drops ready at T+2 and raises it 30 cycles later -> spi_start=3'b010 at T+1, ch_busy[1]=1, r0_done 1 cycle after ready rises.
- r0 and r1 both valid, targets 0 and 2 -> r0 granted first, r1 3 cycles later; both channels busy concurrently; dones route to the correct owners.
- r0 valid, target 0, ch0 busy; r1 valid, target 1 -> r1 granted immediately while r0 waits.
- r1 sends target 3; a second command has depth 0; a third has depth 55 -> each accepted with r1_err at T+1, spi_start never asserted.
- BFM holds spi_ready[2]=1 after start -> r0_err at T+10, ch_busy[2]=0, next command to channel 2 accepted.
- rst_n low for 1 cycle while ch_busy=3'b011 -> all outputs 0 next cycle, no done pulses, round-robin pointer back to r0.
